serializer_tx: RTL

Parallel-to-serial transmit stage in the SERDES path, placed directly downstream of the scrambler. It accepts one 32-bit packet (four byte fields) per handshake and emits a framed serial bitstream: an 8-bit sync pattern, then 32 data bits MSB-first starting with field0, then one even-parity bit. A one-entry holding register lets the next packet be accepted while the current frame is still being sent, so frames can go back-to-back with no idle gap.

---
 rtl/serializer_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serializer_tx.sv
// serializer_tx: parallel-to-serial transmit stage.
// Accepts one 32-bit packet per in_en/in_ready handshake into a one-entry
// holding register and emits a 41-bit frame on ser_out: the 8-bit sync
// pattern MSB-first, the 32 data bits MSB-first (field0 first), then one
// even-parity bit.  The holding register refills while a frame is being
// sent, so consecutive frames follow each other with no idle cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   in_data     packet: field0=[31:24], field1=[23:16], field2=[15:8], field3=[7:0]
//   in_en       upstream data valid
//   in_ready    holding register empty (combinational from hold_valid and rst)
//   ser_out     serial bit (registered)
//   ser_valid   ser_out carries a frame bit (registered)
//   frame_start high during the first sync bit of each frame (registered)
//   busy        frame in progress or word held (registered)
module serializer_tx #(
  parameter logic [7:0] SYNC_PATTERN = 8'hA5,
  parameter logic       IDLE_LEVEL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_en,
  output logic        in_ready,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        frame_start,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] hold_reg, hold_reg_n;
  logic        hold_valid, hold_valid_n;
  logic [31:0] sh, sh_n;
  logic [5:0]  cnt, cnt_n;
  logic        par, par_n;
  logic        ser_out_n, ser_valid_n, frame_start_n, busy_n;
  logic        accept, load;

  assign in_ready = rst && !hold_valid;
  assign accept   = in_en && in_ready;

  always_comb begin
    state_n       = state;
    hold_reg_n    = hold_reg;
    hold_valid_n  = hold_valid;
    sh_n          = sh;
    cnt_n         = cnt;
    par_n         = par;
    ser_out_n     = IDLE_LEVEL;
    ser_valid_n   = 1'b0;
    frame_start_n = 1'b0;
    load          = 1'b0;

    unique case (state)
      IDLE: begin
        if (hold_valid) load = 1'b1;
      end
      SYNC: begin
        ser_out_n     = SYNC_PATTERN[3'd7 - cnt[2:0]];
        ser_valid_n   = 1'b1;
        frame_start_n = (cnt == 6'd0);
        if (cnt == 6'd7) begin
          state_n = DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      DATA: begin
        ser_out_n   = sh[31];
        ser_valid_n = 1'b1;
        sh_n        = {sh[30:0], 1'b0};
        par_n       = par ^ sh[31];
        if (cnt == 6'd31) begin
          state_n = PARITY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      PARITY: begin
        ser_out_n   = par;
        ser_valid_n = 1'b1;
        if (hold_valid) load = 1'b1;
        else            state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Load from the holding register (IDLE or end of PARITY). in_ready is
    // low whenever hold_valid is set, so a load and an accept never coincide.
    if (load) begin
      sh_n         = hold_reg;
      hold_valid_n = 1'b0;
      par_n        = 1'b0;
      cnt_n        = '0;
      state_n      = SYNC;
    end

    if (accept) begin
      hold_reg_n   = in_data;
      hold_valid_n = 1'b1;
    end

    busy_n = (state_n != IDLE) || hold_valid_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      hold_reg    <= '0;
      hold_valid  <= 1'b0;
      sh          <= '0;
      cnt         <= '0;
      par         <= 1'b0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      hold_reg    <= hold_reg_n;
      hold_valid  <= hold_valid_n;
      sh          <= sh_n;
      cnt         <= cnt_n;
      par         <= par_n;
      ser_out     <= ser_out_n;
      ser_valid   <= ser_valid_n;
      frame_start <= frame_start_n;
      busy        <= busy_n;
    end
  end

endmodule
